// File: rtl/sc_fsm_act_if.sv
// Stream/frame bus of the SC FSM activation unit: stream input, frame control and outputs.
interface sc_fsm_act_if #(
  parameter int N   = 4,
  parameter int LEN = 256
);
  localparam int CW = $clog2(LEN + 1);

  logic            start;
  logic [1:0]      mode;
  logic            in_valid;
  logic [N-1:0]    x;
  logic [N-1:0]    y;
  logic            y_valid;
  logic            frame_done;
  logic [N*CW-1:0] count;
  logic            count_valid;

  modport master (
    output start, mode, in_valid, x,
    input  y, y_valid, frame_done, count, count_valid
  );

  modport slave (
    input  start, mode, in_valid, x,
    output y, y_valid, frame_done, count, count_valid
  );
endinterface

// File: rtl/sc_fsm_act.sv
// N-channel stochastic-computing saturating FSM activation (tanh / abs / ReLU) with frame framing.
// Optional per-channel ones counter of y is built when SC_FSM_ACT_COUNT_EN is defined.
module sc_fsm_act #(
  parameter int N         = 4,
  parameter int S         = 6,
  parameter int LEN       = 256,
  parameter int RELU_JUMP = 3
) (
  input  logic         clk,
  input  logic         reset,
  sc_fsm_act_if.slave  bus
);
  localparam int CW = $clog2(LEN + 1);
  localparam int BW = $clog2(LEN);
  localparam logic [S-1:0]  INIT = {1'b1, {(S-1){1'b0}}};
  localparam logic [S-1:0]  TOP  = {S{1'b1}};
  localparam logic [BW-1:0] LAST = BW'(LEN - 1);

  typedef enum logic [1:0] {
    MODE_TANH = 2'b00,
    MODE_ABS  = 2'b01,
    MODE_RELU = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  function automatic logic act_out(input logic [S-1:0] s, input mode_t m);
    if (m == MODE_ABS || m == MODE_RELU) return s[S-1] ? s[0] : ~s[0];
    return ~s[S-1];
  endfunction

  function automatic logic [S-1:0] fsm_step(input logic [S-1:0] s, input logic xb, input mode_t m);
    if (m == MODE_RELU && s == TOP) return TOP - S'(RELU_JUMP);
    if (xb) return (s == '0) ? s : s - 1'b1;
    return (s == TOP) ? s : s + 1'b1;
  endfunction

  mode_t         lmode, mode_eff;
  logic [S-1:0]  st [N];
  logic [S-1:0]  st_cur [N];
  logic [S-1:0]  st_nxt [N];
  logic [N-1:0]  f_nxt;
  logic [BW-1:0] bitcnt, bit_cur, bit_nxt;
  logic          wrap;
  logic [N-1:0]  y_q;
  logic          y_valid_q, frame_done_q;

  // A start in the same cycle as a bit makes that bit run from INIT under the new mode.
  always_comb begin
    mode_eff = bus.start ? mode_t'(bus.mode) : lmode;
    bit_cur  = bus.start ? '0 : bitcnt;
    wrap     = bus.in_valid && (bit_cur == LAST);
    bit_nxt  = bit_cur;
    if (bus.in_valid) bit_nxt = wrap ? '0 : bit_cur + 1'b1;
    f_nxt    = '0;
    for (int ch = 0; ch < N; ch++) begin
      st_cur[ch] = bus.start ? INIT : st[ch];
      f_nxt[ch]  = act_out(st_cur[ch], mode_eff);
      st_nxt[ch] = bus.in_valid ? fsm_step(st_cur[ch], bus.x[ch], mode_eff) : st_cur[ch];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lmode        <= MODE_TANH;
      bitcnt       <= '0;
      y_q          <= '0;
      y_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      for (int ch = 0; ch < N; ch++) st[ch] <= INIT;
    end else begin
      if (bus.start) lmode <= mode_t'(bus.mode);
      bitcnt       <= bit_nxt;
      y_valid_q    <= bus.in_valid;
      frame_done_q <= wrap;
      if (bus.in_valid) y_q <= f_nxt;
      for (int ch = 0; ch < N; ch++) st[ch] <= st_nxt[ch];
    end
  end

  assign bus.y          = y_q;
  assign bus.y_valid    = y_valid_q;
  assign bus.frame_done = frame_done_q;

`ifdef SC_FSM_ACT_COUNT_EN
  logic [CW-1:0] acc [N];
  logic [CW-1:0] acc_sum [N];
  logic [CW-1:0] cnt_q [N];
  logic          count_valid_q;
  logic [N*CW-1:0] count_flat;

  // Running total includes the bit accepted this cycle, so a wrapping bit lands in the published count.
  always_comb begin
    count_flat = '0;
    for (int ch = 0; ch < N; ch++) begin
      acc_sum[ch] = (bus.start ? '0 : acc[ch]) + CW'(f_nxt[ch]);
      count_flat[ch*CW +: CW] = cnt_q[ch];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_valid_q <= 1'b0;
      for (int ch = 0; ch < N; ch++) begin
        acc[ch]   <= '0;
        cnt_q[ch] <= '0;
      end
    end else begin
      count_valid_q <= wrap;
      for (int ch = 0; ch < N; ch++) begin
        if (bus.in_valid) begin
          if (wrap) begin
            cnt_q[ch] <= acc_sum[ch];
            acc[ch]   <= '0;
          end else begin
            acc[ch]   <= acc_sum[ch];
          end
        end else if (bus.start) begin
          acc[ch] <= '0;
        end
      end
    end
  end

  assign bus.count       = count_flat;
  assign bus.count_valid = count_valid_q;
`else
  assign bus.count       = '0;
  assign bus.count_valid = 1'b0;
`endif
endmodule

// File: tb/tb_sc_fsm_act.sv
// Randomised scoreboard bench for sc_fsm_act: a behavioural model predicts every output cycle.
module tb_sc_fsm_act;
  localparam int N   = 4;
  localparam int S   = 6;
  localparam int LEN = 16;
  localparam int RJ  = 3;
  localparam int CW  = $clog2(LEN + 1);
  localparam int TOP = (1 << S) - 1;
  localparam int HALF = 1 << (S - 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sc_fsm_act_if #(.N(N), .LEN(LEN)) bus ();
  sc_fsm_act #(.N(N), .S(S), .LEN(LEN), .RELU_JUMP(RJ)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int              due;
    logic            yv;
    logic [N-1:0]    y;
    logic            fd;
    logic            cv;
    logic [N*CW-1:0] cnt;
  } rec_t;

  rec_t q[$];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  // Reference state: plain integers per the activation rules
  int st_m [N];
  int acc_m [N];
  int lmode_m, bits_m;
  logic [N-1:0]    y_m;
  logic [N*CW-1:0] cnt_m;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic f_of(input int s, input int m);
    if (m == 1 || m == 2) return (s < HALF) ? (s % 2 == 0) : (s % 2 == 1);
    return s < HALF;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin st_m[c] = HALF; acc_m[c] = 0; end
    lmode_m = 0; bits_m = 0; y_m = '0; cnt_m = '0;
  endtask

  task automatic step(input logic st_in, input logic [1:0] md, input logic v, input logic [N-1:0] xb);
    rec_t r;
    @(posedge clk); #1;
    bus.start = st_in; bus.mode = md; bus.in_valid = v; bus.x = xb;
    if (st_in) begin
      for (int c = 0; c < N; c++) begin st_m[c] = HALF; acc_m[c] = 0; end
      bits_m = 0; lmode_m = md;
    end
    r.fd = 1'b0; r.cv = 1'b0;
    if (v) begin
      for (int c = 0; c < N; c++) begin
        y_m[c] = f_of(st_m[c], lmode_m);
        acc_m[c] += y_m[c];
        if (lmode_m == 2 && st_m[c] == TOP) st_m[c] = TOP - RJ;
        else if (xb[c]) st_m[c] = (st_m[c] > 0) ? st_m[c] - 1 : 0;
        else st_m[c] = (st_m[c] < TOP) ? st_m[c] + 1 : TOP;
      end
      bits_m++;
      if (bits_m == LEN) begin
        bits_m = 0;
        r.fd = 1'b1;
`ifdef SC_FSM_ACT_COUNT_EN
        r.cv = 1'b1;
        for (int c = 0; c < N; c++) cnt_m[c*CW +: CW] = CW'(acc_m[c]);
`endif
        for (int c = 0; c < N; c++) acc_m[c] = 0;
      end
    end
    r.due = cyc + 1; r.yv = v; r.y = y_m; r.cnt = cnt_m;
    q.push_back(r);
  endtask

  task automatic async_reset();
    rec_t r;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b0;
    #6 reset = 1'b1;
    #1;
    chk("reset_y_now", 64'(bus.y), 64'(0));
    chk("reset_yv_now", 64'(bus.y_valid), 64'(0));
    model_reset();
    r.due = cyc + 1; r.yv = 1'b0; r.y = '0; r.fd = 1'b0; r.cv = 1'b0; r.cnt = '0;
    q.push_back(r);
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the record due this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      rec_t r;
      r = q.pop_front();
      if (r.due < cyc) begin
        chk("stale_record", 64'(r.due), 64'(cyc));
      end else begin
        chk("y_valid", 64'(bus.y_valid), 64'(r.yv));
        chk("y", 64'(bus.y), 64'(r.y));
        chk("frame_done", 64'(bus.frame_done), 64'(r.fd));
        chk("count_valid", 64'(bus.count_valid), 64'(r.cv));
        chk("count", 64'(bus.count), 64'(r.cnt));
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.mode = 2'b00; bus.in_valid = 1'b0; bus.x = '0;
    model_reset();
    #2;
    chk("por_y", 64'(bus.y), 64'(0));
    chk("por_y_valid", 64'(bus.y_valid), 64'(0));
    chk("por_frame_done", 64'(bus.frame_done), 64'(0));
    chk("por_count", 64'(bus.count), 64'(0));
    chk("por_count_valid", 64'(bus.count_valid), 64'(0));
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;

    // tanh, x=1 held: full frames, count of ones per frame
    step(1'b1, 2'b00, 1'b1, '1);
    for (int i = 0; i < 39; i++) step(1'b0, 2'b01, 1'b1, '1);
    // abs, x=1 held
    step(1'b1, 2'b01, 1'b1, '1);
    for (int i = 0; i < 39; i++) step(1'b0, 2'b00, 1'b1, '1);
    // relu, x=0 held: climb to top then 63->60->61->62->63 cycling
    step(1'b1, 2'b10, 1'b1, '0);
    for (int i = 0; i < 59; i++) step(1'b0, 2'b11, 1'b1, '0);
    // reserved mode behaves as tanh, x=0 held
    step(1'b1, 2'b11, 1'b1, '0);
    for (int i = 0; i < 40; i++) step(1'b0, 2'b10, 1'b1, '0);
    // framing with in_valid toggling, then start mid-frame at bit 5
    step(1'b1, 2'b01, 1'b1, N'($urandom));
    for (int i = 1; i < 4 * LEN; i++) step(1'b0, 2'b00, i[0] == 1'b0, N'($urandom));
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 1'b1, N'($urandom));
    step(1'b1, 2'b10, 1'b1, N'($urandom));
    for (int i = 0; i < 2 * LEN + 3; i++) step(1'b0, 2'b01, 1'b1, N'($urandom));
    // randomized mix: mode noise, sparse starts, random valid and streams
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 39) == 0, 2'($urandom), $urandom_range(0, 3) != 0, N'($urandom));
    // reset mid-frame, then continue without start: tanh from INIT
    step(1'b1, 2'b10, 1'b1, '0);
    for (int i = 0; i < 6; i++) step(1'b0, 2'b10, 1'b1, N'($urandom));
    async_reset();
    for (int i = 0; i < 3 * LEN; i++) step(1'b0, 2'b01, $urandom_range(0, 4) != 0, N'($urandom));
    step(1'b0, 2'b00, 1'b0, '0);
    repeat (3) @(posedge clk);
    #6;
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sc_fsm_act.md
# sc_fsm_act

Parametrised multi-channel stochastic-computing FSM activation unit. Each of N channels runs a saturating up/down state machine over a bipolar stochastic bitstream and emits a transformed stream whose function is selected at frame start: tanh, abs or ReLU. The unit adds valid-qualified input, frame framing and a registered output. It sits between the SC multiply/accumulate stage and the next layer's stream input.

## Interface
- N, 4, number of independent channels
- S, 6, state register width per channel (2^S states)
- LEN, 256, bits per frame (>= 2)
- RELU_JUMP, 3, ReLU backstep from top state (odd, 1 <= RELU_JUMP <= 2^S-2)

- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  frame start pulse; reinitialises all channels, latches mode
- mode  input  2  00 tanh, 01 abs, 10 relu, 11 reserved (behaves as tanh)
- in_valid  input  1  x bits valid this cycle
- x  input  N  one stream bit per channel
- y  output  N  registered output bits
- y_valid  output  1  y holds a valid bit
- frame_done  output  1  pulse with the y of the LEN-th bit of a frame
- count  output  N*$clog2(LEN+1)  per-channel ones count of y over the frame (see Configuration)
- count_valid  output  1  count holds a completed frame total

## Operation
- Per-channel state st in 0..2^S-1; INIT = 2^(S-1).
- Update only on in_valid. x=1 moves st down, x=0 moves st up.
- Saturation: st=0 with x=1 stays 0; st=2^S-1 with x=0 stays 2^S-1 (tanh/abs).
- ReLU mode: st=2^S-1 goes to 2^S-1-RELU_JUMP regardless of x; other transitions as above.
- Output f(st) uses pre-update state:
  - tanh: f = ~st[S-1].
  - abs/relu: f = (st[S-1]==0) ? ~st[0] : st[0].
- Latched mode register (lmode) is loaded from mode only on start; mode changes mid-frame are ignored.
- start: all st <= INIT, bit counter <= 0, count accumulators <= 0. If in_valid in the same cycle, that bit is processed from INIT under the new mode.
- start without in_valid produces no output. start mid-frame aborts the frame: no frame_done, partial counts discarded.
- Bit counter increments per accepted bit. On the LEN-th bit it wraps to 0, frame_done fires, and the next frame begins without start. States are not reinitialised on wrap.
- Reset: st=INIT, lmode=tanh, counter=0, y=0, y_valid=0, frame_done=0, count=0, count_valid=0.

## Timing
- Latency 1: bit accepted at cycle t gives y/y_valid at t+1. y_valid is a copy of in_valid delayed by one cycle.
- y holds its last value while y_valid=0.
- frame_done and count_valid are single-cycle, coincident with y_valid of the LEN-th bit. count includes that bit. count then holds until the next frame completes.
- Back-to-back in_valid sustains one bit per cycle with no bubbles.
- Reset asserted mid-frame clears everything immediately (asynchronous). The first bit after deassertion is processed from INIT.

## Configuration
- SC_FSM_ACT_COUNT_EN defined: per-channel $clog2(LEN+1)-bit ones counter of y. The counter is cleared on start and on frame wrap. The total is published on count with count_valid.
- Not defined: count and count_valid ports remain, tied to 0. No counter logic is present.

## Test plan
- Tanh, N=1, S=6, x=1 held 40 valid cycles after start -> y sequence 0 then 1 x39; st reaches 0 after 32 bits and stays there.
- Abs, x=1 held -> states 32,31,30,... give y = 0,0,1,0,1,...; stream of 0.5 bipolar (~x=0) input gives y mean ~0.
- Relu, x=0 held 60 cycles -> st climbs 32..63, then cycles 63->60->61->62->63. In steady state y alternates 0,1,0,1.
- Framing, LEN=8, in_valid toggling 1/0 -> frame_done pulses on every 8th y_valid. start asserted at bit 5 with in_valid -> no frame_done; the new frame ends 8 accepted bits later.
- Count (SC_FSM_ACT_COUNT_EN), LEN=256, tanh, x=1 all frame -> count=255, count_valid pulse with frame_done. Without macro -> count=0, count_valid=0.
- Reset asserted at bit 100 of a frame -> y=0, y_valid=0 immediately. Next bit starts from st=32 with lmode=tanh.
